// File: rtl/cmp_pkg.sv
// Shared constants for the comparator pair enumerator: relation bits, mode values and FSM states.
package cmp_pkg;

  localparam logic [2:0] REL_G = 3'b100;
  localparam logic [2:0] REL_E = 3'b010;
  localparam logic [2:0] REL_L = 3'b001;

  localparam logic MODE_UNS = 1'b1;
  localparam logic MODE_SGN = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_EMIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/cmp_rel_eval.sv
// Combinational G/E/L relation of two W-bit operands, unsigned or two's complement.
// Also serves as the golden comparator model for comparator benches.
module cmp_rel_eval
  import cmp_pkg::*;
#(
  parameter int W = 3
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         s_i,
  output logic         g_o,
  output logic         e_o,
  output logic         l_o
);

  // Exactly one of the three outputs is high for any operand pair.
  always_comb begin
    e_o = (a_i == b_i);
    if (s_i == MODE_UNS) begin
      g_o = (a_i > b_i);
    end else begin
      g_o = ($signed(a_i) > $signed(b_i));
    end
    l_o = ~g_o & ~e_o;
  end

endmodule

// File: rtl/cmp_pair_enumerator.sv
// Walks every (a,b) operand pair in ascending a-major order and streams out those matching
// the latched relation set. Optional match counter enabled by defining CMP_ENUM_COUNT_EN.
module cmp_pair_enumerator
  import cmp_pkg::*;
#(
  parameter int W = 3
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [2:0]   rel_sel_i,
  input  logic         s_i,
  output logic [W-1:0] a_o,
  output logic [W-1:0] b_o,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic         busy_o,
  output logic         done_o
`ifdef CMP_ENUM_COUNT_EN
  ,
  output logic [2*W:0] match_count_o
`endif
);

  localparam int IW = 2 * W;
  localparam logic [IW-1:0] IDX_MAX = '1;
  localparam logic [IW-1:0] IDX_ONE = {{(IW - 1) {1'b0}}, 1'b1};

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [2:0]      rel_q, rel_d;
  logic            s_q, s_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic            valid_q, valid_d;

  logic [W-1:0]    a_cand, b_cand;
  logic            rel_g, rel_e, rel_l;
  logic            match;

  assign a_cand = idx_q[IW-1:W];
  assign b_cand = idx_q[W-1:0];

  cmp_rel_eval #(
    .W(W)
  ) u_rel_eval (
    .a_i(a_cand),
    .b_i(b_cand),
    .s_i(s_q),
    .g_o(rel_g),
    .e_o(rel_e),
    .l_o(rel_l)
  );

  assign match = |(rel_q & {rel_g, rel_e, rel_l});

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      rel_q   <= '0;
      s_q     <= MODE_SGN;
      a_q     <= '0;
      b_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rel_q   <= rel_d;
      s_q     <= s_d;
      a_q     <= a_d;
      b_q     <= b_d;
      valid_q <= valid_d;
    end
  end

  // rel_sel and mode are captured only on a start accepted in IDLE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rel_d   = rel_q;
    s_d     = s_q;
    a_d     = a_q;
    b_d     = b_q;
    valid_d = valid_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_SCAN;
          idx_d   = '0;
          rel_d   = rel_sel_i;
          s_d     = s_i;
        end
      end
      ST_SCAN: begin
        if (match) begin
          a_d     = a_cand;
          b_d     = b_cand;
          valid_d = 1'b1;
          state_d = ST_EMIT;
        end else if (idx_q == IDX_MAX) begin
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + IDX_ONE;
        end
      end
      ST_EMIT: begin
        if (out_ready_i) begin
          valid_d = 1'b0;
          if (idx_q == IDX_MAX) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + IDX_ONE;
            state_d = ST_SCAN;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

`ifdef CMP_ENUM_COUNT_EN
  localparam logic [IW:0] CNT_ONE = {{IW{1'b0}}, 1'b1};

  logic [IW:0] count_q, count_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  always_comb begin
    count_d = count_q;
    if (state_q == ST_IDLE && start_i) begin
      count_d = '0;
    end else if (state_q == ST_EMIT && out_ready_i) begin
      count_d = count_q + CNT_ONE;
    end
  end

  assign match_count_o = count_q;
`endif

  assign a_o         = a_q;
  assign b_o         = b_q;
  assign out_valid_o = valid_q;
  assign busy_o      = (state_q == ST_SCAN) || (state_q == ST_EMIT);
  assign done_o      = (state_q == ST_DONE);

endmodule

// File: tb/tb_cmp_pair_enumerator.sv
// Self-checking bench for cmp_pair_enumerator: table vectors, corner sequences and random scans
// compared against an arithmetic pair-list model. Covers match_count when CMP_ENUM_COUNT_EN is defined.
module tb_cmp_pair_enumerator;

  localparam int W = 3;
  localparam int N = 1 << W;

  typedef struct {
    logic [2:0] rel;
    logic       s;
    int         readyMode;
    int         expCount;
    int         firstCode;
    int         lastCode;
  } vec_t;

  logic         clk;
  logic         rst;
  logic         startIn;
  logic [2:0]   relSel;
  logic         sMode;
  logic [W-1:0] aOut;
  logic [W-1:0] bOut;
  logic         outValid;
  logic         outReady;
  logic         busy;
  logic         done;
`ifdef CMP_ENUM_COUNT_EN
  logic [2*W:0] matchCount;
`endif

  int checks;
  int errors;
  int expQ[$];
  int gotQ[$];
  int doneSeen;
  vec_t vecs[5];

  cmp_pair_enumerator #(
    .W(W)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .start_i(startIn),
    .rel_sel_i(relSel),
    .s_i(sMode),
    .a_o(aOut),
    .b_o(bOut),
    .out_valid_o(outValid),
    .out_ready_i(outReady),
    .busy_o(busy),
    .done_o(done)
`ifdef CMP_ENUM_COUNT_EN
    ,
    .match_count_o(matchCount)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every comparison funnels through here so the counts stay honest.
  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic int opValue(input int v, input logic s);
    if (s) return v;
    return (v >= N / 2) ? v - N : v;
  endfunction

  // Reference: list every pair satisfying the relation set, a-major ascending.
  task automatic buildExpected(input logic [2:0] rel, input logic s);
    int x, y;
    bit hit;
    expQ.delete();
    for (int a = 0; a < N; a++) begin
      for (int b = 0; b < N; b++) begin
        x   = opValue(a, s);
        y   = opValue(b, s);
        hit = (rel[2] && x > y) || (rel[1] && x == y) || (rel[0] && x < y);
        if (hit) expQ.push_back(a * N + b);
      end
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Launch one scan and collect every handshaken pair until done, checking stalls for stability.
  task automatic applyStimulus(input logic [2:0] rel, input logic s, input int readyMode,
                               input bit noise);
    bit stalled;
    int heldCode;
    bit finished;
    gotQ.delete();
    doneSeen = 0;
    stalled  = 0;
    heldCode = 0;
    finished = 0;
    relSel   = rel;
    sMode    = s;
    outReady = 1'b0;
    startIn  = 1'b1;
    nextCycle();
    startIn = 1'b0;
    checkOutput("busyAfterStart", int'(busy), 1);
    checkOutput("validAfterStart", int'(outValid), 0);
`ifdef CMP_ENUM_COUNT_EN
    checkOutput("countClearedOnStart", int'(matchCount), 0);
`endif
    for (int cyc = 0; cyc < 2000 && !finished; cyc++) begin
      if (stalled) begin
        checkOutput("stallValidHeld", int'(outValid), 1);
        checkOutput("stallPairHeld", int'(aOut) * N + int'(bOut), heldCode);
      end
      if (done) begin
        doneSeen++;
        checkOutput("validAtDone", int'(outValid), 0);
        startIn  = 1'b0;
        outReady = 1'b0;
        finished = 1;
      end else begin
        case (readyMode)
          0:       outReady = 1'b1;
          1:       outReady = (cyc % 3 == 2);
          default: outReady = 1'($urandom_range(0, 1));
        endcase
        if (outValid && outReady) gotQ.push_back(int'(aOut) * N + int'(bOut));
        stalled  = outValid && !outReady;
        heldCode = int'(aOut) * N + int'(bOut);
        if (noise) begin
          startIn = 1'($urandom_range(0, 1));
          relSel  = 3'($urandom_range(0, 7));
          sMode   = 1'($urandom_range(0, 1));
        end
      end
      nextCycle();
    end
    startIn = 1'b0;
    if (!finished) checkOutput("scanTimeout", 1, 0);
    checkOutput("doneOnePulse", int'(done), 0);
    checkOutput("busyFallsAfterDone", int'(busy), 0);
`ifdef CMP_ENUM_COUNT_EN
    checkOutput("matchCountHeld", int'(matchCount), expQ.size());
`endif
  endtask

  task automatic compareStream(input string tag);
    checkOutput({tag, ".pairCount"}, gotQ.size(), expQ.size());
    for (int i = 0; i < gotQ.size() && i < expQ.size(); i++) begin
      if (gotQ[i] != expQ[i]) checkOutput({tag, ".pair"}, gotQ[i], expQ[i]);
    end
    checks++;
  endtask

  function automatic int findPair(input int code);
    foreach (gotQ[i]) if (gotQ[i] == code) return 1;
    return 0;
  endfunction

  initial begin
    int busyCycles;
    int validSeen;
    bit waited;
    logic [2:0] rRel;
    logic       rS;

    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    startIn  = 1'b0;
    relSel   = 3'b000;
    sMode    = 1'b1;
    outReady = 1'b0;

    vecs[0] = '{rel: 3'b100, s: 1'b1, readyMode: 0, expCount: 28, firstCode: 1 * N + 0, lastCode: 7 * N + 6};
    vecs[1] = '{rel: 3'b100, s: 1'b0, readyMode: 0, expCount: 28, firstCode: 0 * N + 4, lastCode: 7 * N + 6};
    vecs[2] = '{rel: 3'b010, s: 1'b1, readyMode: 1, expCount: 8,  firstCode: 0,         lastCode: 7 * N + 7};
    vecs[3] = '{rel: 3'b110, s: 1'b1, readyMode: 2, expCount: 36, firstCode: 0,         lastCode: 7 * N + 7};
    vecs[4] = '{rel: 3'b011, s: 1'b0, readyMode: 2, expCount: 36, firstCode: 0,         lastCode: 7 * N + 7};

    repeat (3) nextCycle();
    checkOutput("resetA", int'(aOut), 0);
    checkOutput("resetB", int'(bOut), 0);
    checkOutput("resetValid", int'(outValid), 0);
    checkOutput("resetBusy", int'(busy), 0);
    checkOutput("resetDone", int'(done), 0);
`ifdef CMP_ENUM_COUNT_EN
    checkOutput("resetCount", int'(matchCount), 0);
`endif
    rst = 1'b0;
    nextCycle();

    for (int i = 0; i < 5; i++) begin
      buildExpected(vecs[i].rel, vecs[i].s);
      applyStimulus(vecs[i].rel, vecs[i].s, vecs[i].readyMode, 1'b0);
      $display("[TB] vector %0d rel=%b s=%0d: %0d pairs", i, vecs[i].rel, vecs[i].s, gotQ.size());
      checkOutput("vecCount", gotQ.size(), vecs[i].expCount);
      checkOutput("vecFirst", (gotQ.size() > 0) ? gotQ[0] : -1, vecs[i].firstCode);
      checkOutput("vecLast", (gotQ.size() > 0) ? gotQ[gotQ.size() - 1] : -1, vecs[i].lastCode);
      checkOutput("vecDonePulses", doneSeen, 1);
      compareStream("vec");
      if (i == 1) begin
        checkOutput("signedPair3_7Present", findPair(3 * N + 7), 1);
        checkOutput("signedPair4_3Absent", findPair(4 * N + 3), 0);
      end
    end

    // Empty relation: 64 scan cycles, no output, a single done pulse.
    relSel   = 3'b000;
    sMode    = 1'b1;
    outReady = 1'b1;
    startIn  = 1'b1;
    nextCycle();
    startIn    = 1'b0;
    busyCycles = 0;
    validSeen  = 0;
    doneSeen   = 0;
    for (int cyc = 0; cyc < 200 && doneSeen == 0; cyc++) begin
      if (busy) busyCycles++;
      if (outValid) validSeen++;
      if (done) doneSeen++;
      nextCycle();
    end
    checkOutput("emptyBusyCycles", busyCycles, 64);
    checkOutput("emptyValidSeen", validSeen, 0);
    checkOutput("emptyDonePulses", doneSeen, 1);
    checkOutput("emptyDoneDrops", int'(done), 0);
    checkOutput("emptyBusyFalls", int'(busy), 0);

    // Reset while a pair is pending in EMIT: everything returns to reset values, no done.
    relSel   = 3'b100;
    sMode    = 1'b1;
    outReady = 1'b0;
    startIn  = 1'b1;
    nextCycle();
    startIn = 1'b0;
    waited  = 0;
    for (int cyc = 0; cyc < 20 && !waited; cyc++) begin
      if (outValid) waited = 1;
      else nextCycle();
    end
    checkOutput("emitReached", int'(waited), 1);
    checkOutput("emitFirstPair", int'(aOut) * N + int'(bOut), 1 * N + 0);
    rst = 1'b1;
    nextCycle();
    rst = 1'b0;
    checkOutput("abortA", int'(aOut), 0);
    checkOutput("abortB", int'(bOut), 0);
    checkOutput("abortValid", int'(outValid), 0);
    checkOutput("abortBusy", int'(busy), 0);
    checkOutput("abortDone", int'(done), 0);
    doneSeen = 0;
    repeat (4) begin
      nextCycle();
      if (done) doneSeen++;
    end
    checkOutput("abortNoDonePulse", doneSeen, 0);
    buildExpected(3'b100, 1'b1);
    applyStimulus(3'b100, 1'b1, 0, 1'b0);
    compareStream("rescan");
    checkOutput("rescanFirst", (gotQ.size() > 0) ? gotQ[0] : -1, 1 * N + 0);

    // Random configurations with random backpressure and input noise during the scan.
    for (int r = 0; r < 8; r++) begin
      rRel = 3'($urandom_range(0, 7));
      rS   = 1'($urandom_range(0, 1));
      buildExpected(rRel, rS);
      applyStimulus(rRel, rS, 2, 1'b1);
      $display("[TB] random run %0d rel=%b s=%0d: %0d pairs", r, rRel, rS, gotQ.size());
      checkOutput("randDonePulses", doneSeen, 1);
      compareStream("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
